mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the single memory port between the core's load/store/fetch interface and a debug/loader requester.
- Sits between the core and the memory model. Sequences every access as a request/ready transaction on the memory side and stalls the core through `core_wait`, which feeds the control unit's wait input.
- The core has priority. An age counter guarantees the debug port is never starved.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: cycles the debug port may wait while losing arbitration before it is forced to win.
- `CNT_W`, default $clog2(STARVE_LIMIT+1): width of the age counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `core_addr`  in  32 (`word_t`)  core byte address.
- `core_rden`  in  1  core read request, level.
- `core_wren`  in  1  core write request, level.
- `core_size`  in  `mem_addr_t`  access size (byte/half/word).
- `core_wdata`  in  `word_t`  core store data.
- `core_rdata`  out  `word_t`  read data; valid in the cycle `core_wait` is low after a read.
- `core_wait`  out  1  stall core; high while a core request is not completing this cycle.
- `dbg_req`  in  1  debug request, level; held until `dbg_ack`.
- `dbg_we`  in  1  debug write (1) / read (0).
- `dbg_addr`  in  `word_t`  debug address.
- `dbg_size`  in  `mem_addr_t`  debug access size.
- `dbg_wdata`  in  `word_t`  debug store data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  `word_t`  registered read data; valid with `dbg_ack` and held until the next debug completion.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  `word_t`  memory address.
- `mem_size`  out  `mem_addr_t`  memory access size.
- `mem_wdata`  out  `word_t`  memory store data.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  `word_t`  memory read data; valid with `mem_ready`.

## Operation
States: `IDLE`, `CORE`, `DBG`.

- **Core pending:** `core_rden | core_wren`. If both are high, the access is a write.
- **IDLE:** arbitrate.
  - Debug wins if `dbg_req` is high and either the core is idle or `age == STARVE_LIMIT`.
  - Otherwise a pending core request wins.
  - With no request, the FSM stays in IDLE.
- **Grant register:** on a grant, the requester's addr/size/wdata/we are registered into the mem_* outputs and the FSM moves to `CORE`/`DBG`.
- **CORE/DBG:**
  - `mem_req` is high and all mem_* outputs are held stable.
  - On `mem_ready` the FSM returns to IDLE.
  - CORE: `core_rdata = mem_rdata` combinationally; `core_wait` is low that cycle.
  - DBG: `dbg_rdata <= mem_rdata` (reads only) and `dbg_ack` pulses the next cycle.
- **core_wait** = core pending AND NOT (state == CORE AND `mem_ready`).
- **age counter:**
  - Increments each cycle `dbg_req` is high and state != DBG; saturates at `STARVE_LIMIT`.
  - Clears on a debug grant.
  - Clears when `dbg_req` is low.
- **Debug withdrawal:** `dbg_req` may drop before its grant; the request is simply withdrawn. Dropping it after the grant has no effect; the transaction completes and `dbg_ack` still pulses.
- **Core requests:** the core holds its request until `core_wait` is low. Changing the fields mid-request is a core bug; the latched values are used.

## Timing
- **Reset values (rst low at an edge):**
  - state = IDLE and `age` = 0.
  - `mem_req`, `mem_we`, `dbg_ack` = 0.
  - `mem_addr`, `mem_size`, `mem_wdata`, `dbg_rdata` = 0.
  - `core_wait` follows its equation from IDLE, so it is high if the core is pending.
- **Reset mid-transaction:** the transaction is abandoned, `mem_req` is low after the edge, and no ack is issued. The memory tolerates abort.
- **Minimum latency:** 2 cycles per access (IDLE arbitrate, then grant state with zero-wait `mem_ready`). Each extra wait cycle of `mem_ready` adds one cycle.
- **Back-to-back accesses:** always pass through IDLE; there is one bubble between transactions.
- **dbg_ack:** asserted exactly one cycle, one cycle after the `mem_ready` edge of its transaction.
- **Simultaneous requests in IDLE:** the core wins unless `age == STARVE_LIMIT`.

## Structure
- Shared package holds `word_t`, `mem_addr_t` and the access-size encodings, plus a new `arb_state_t` enum (IDLE/CORE/DBG).
- One natural sub-module, `arb_age_cnt`: a saturating counter with inc/clr/limit-reached outputs, parameterised by `STARVE_LIMIT`.

## Test plan
- **Core-only read:** core read 0x100, `mem_ready` tied high; `mem_rdata` 0xDEADBEEF → `core_wait` high for 1 cycle, then low with `core_rdata` = 0xDEADBEEF; `mem_req` high for exactly 1 cycle.
- **Debug write with memory waits:** debug write 0x200 ← 0x12345678, 3 wait cycles → `mem_we` = 1 and mem_* fields stable for 4 cycles; `dbg_ack` pulses once, 1 cycle after `mem_ready`.
- **Starvation:** continuous core requests plus `dbg_req` with STARVE_LIMIT = 8 → debug is granted within 8 core transactions once `age` hits 8; `age` clears on the grant.
- **Simultaneous start:** core and debug request in the same IDLE cycle with `age` = 0 → core granted first, debug next.
- **Reset mid-transaction:** rst low during DBG while `mem_ready` is low → next cycle `mem_req` = 0, state IDLE, no `dbg_ack`, `age` = 0.
- **Read+write conflict:** `core_rden` and `core_wren` both high → `mem_we` = 1 (write wins); debug withdrawal before grant → no memory access issued.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: bus word, access size encodings,
// arbiter state and the latched memory command.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  mem_addr_t;

  localparam mem_addr_t SIZE_BYTE = 2'b00;
  localparam mem_addr_t SIZE_HALF = 2'b01;
  localparam mem_addr_t SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic      we;
    mem_addr_t size;
    word_t     addr;
    word_t     wdata;
  } mem_cmd_t;

  function automatic mem_cmd_t make_cmd(input logic      we,
                                        input mem_addr_t size,
                                        input word_t     addr,
                                        input word_t     wdata);
    mem_cmd_t cmd;
    cmd.we    = we;
    cmd.size  = size;
    cmd.addr  = addr;
    cmd.wdata = wdata;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arbiter_age_cnt.sv
// Saturating age counter that tracks how long the debug requester has been
// losing arbitration; limit_o forces the next debug win.
module arb_age_cnt #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear takes precedence so a debug grant restarts the aging window.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: core has priority, the debug/loader port
// is protected from starvation by an age counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic      clk,
  input  logic      rst,
  input  word_t     core_addr,
  input  logic      core_rden,
  input  logic      core_wren,
  input  mem_addr_t core_size,
  input  word_t     core_wdata,
  output word_t     core_rdata,
  output logic      core_wait,
  input  logic      dbg_req,
  input  logic      dbg_we,
  input  word_t     dbg_addr,
  input  mem_addr_t dbg_size,
  input  word_t     dbg_wdata,
  output logic      dbg_ack,
  output word_t     dbg_rdata,
  output logic      mem_req,
  output logic      mem_we,
  output word_t     mem_addr,
  output mem_addr_t mem_size,
  output word_t     mem_wdata,
  input  logic      mem_ready,
  input  word_t     mem_rdata
);

  arb_state_t state_q;
  mem_cmd_t   cmd_q;
  logic       mem_req_q;
  logic       dbg_ack_q;
  word_t      dbg_rdata_q;

  logic core_pending;
  logic age_limit;
  logic dbg_wins;
  logic grant_dbg;
  logic grant_core;

  assign core_pending = core_rden | core_wren;
  assign dbg_wins     = dbg_req & (~core_pending | age_limit);
  assign grant_dbg    = (state_q == IDLE) & dbg_wins;
  assign grant_core   = (state_q == IDLE) & ~dbg_wins & core_pending;

  arb_age_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_age_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (dbg_req & (state_q != DBG)),
    .clr_i  (~dbg_req | grant_dbg),
    .limit_o(age_limit)
  );

  // Every access passes through IDLE, giving one bubble between transactions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      mem_req_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      dbg_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dbg) begin
            state_q   <= DBG;
            mem_req_q <= 1'b1;
            cmd_q     <= make_cmd(dbg_we, dbg_size, dbg_addr, dbg_wdata);
          end else if (grant_core) begin
            state_q   <= CORE;
            mem_req_q <= 1'b1;
            cmd_q     <= make_cmd(core_wren, core_size, core_addr, core_wdata);
          end
        end
        CORE: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        DBG: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            dbg_ack_q <= 1'b1;
            if (!cmd_q.we) begin
              dbg_rdata_q <= mem_rdata;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_size  = cmd_q.size;
  assign mem_wdata = cmd_q.wdata;

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

  // Core read data passes straight through in the completing cycle.
  assign core_rdata = (state_q == CORE) ? mem_rdata : '0;
  assign core_wait  = core_pending & ~((state_q == CORE) & mem_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic scored against a transaction-level memory and requester model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE = 8;

  logic      clk = 1'b0;
  logic      rst;
  word_t     core_addr;
  logic      core_rden;
  logic      core_wren;
  mem_addr_t core_size;
  word_t     core_wdata;
  word_t     core_rdata;
  logic      core_wait;
  logic      dbg_req;
  logic      dbg_we;
  word_t     dbg_addr;
  mem_addr_t dbg_size;
  word_t     dbg_wdata;
  logic      dbg_ack;
  word_t     dbg_rdata;
  logic      mem_req;
  logic      mem_we;
  word_t     mem_addr;
  mem_addr_t mem_size;
  word_t     mem_wdata;
  logic      mem_ready;
  word_t     mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .core_addr (core_addr),
    .core_rden (core_rden),
    .core_wren (core_wren),
    .core_size (core_size),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_wait (core_wait),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_size  (dbg_size),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_size  (mem_size),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  int    vectorCount = 0;
  int    missCount   = 0;
  word_t memModel [word_t];

  // Random-phase requester and scoreboard state
  logic  coreActive, coreDone;
  logic  dbgActive, dbgPendingAck, dbgExpIsRead;
  word_t dbgExpRd;
  logic  prevReq, prevDone;
  logic  capWe;
  word_t capAddr, capWdata;
  mem_addr_t capSize;
  int    coresDuringDbg, coreWaitCyc, dbgWaitCyc;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic word_t memRead(input word_t a);
    if (memModel.exists(a)) return memModel[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic idleInputs();
    core_addr  = '0;
    core_rden  = 1'b0;
    core_wren  = 1'b0;
    core_size  = SIZE_BYTE;
    core_wdata = '0;
    dbg_req    = 1'b0;
    dbg_we     = 1'b0;
    dbg_addr   = '0;
    dbg_size   = SIZE_BYTE;
    dbg_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
  endtask

  // Random requesters and memory; the agents react to registered outputs only.
  task automatic applyStimulus();
    int k;
    if (coreDone) coreActive = 1'b0;
    if (!coreActive && ($urandom_range(0, 1) == 1)) begin
      coreActive = 1'b1;
      k          = int'($urandom_range(0, 2));
      core_rden  = (k != 1);
      core_wren  = (k != 0);
      core_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      core_size  = mem_addr_t'($urandom_range(0, 2));
      core_wdata = $urandom;
    end else if (!coreActive) begin
      core_rden = 1'b0;
      core_wren = 1'b0;
    end
    if (dbg_ack) dbgActive = 1'b0;
    if (!dbgActive && ($urandom_range(0, 3) == 0)) begin
      dbgActive = 1'b1;
      dbg_req   = 1'b1;
      dbg_we    = ($urandom_range(0, 1) == 1);
      dbg_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      dbg_size  = mem_addr_t'($urandom_range(0, 2));
      dbg_wdata = $urandom;
    end else if (!dbgActive) begin
      dbg_req = 1'b0;
    end
    mem_ready = mem_req && ($urandom_range(0, 2) == 0);
    mem_rdata = memRead(mem_addr);
  endtask

  initial begin
    int coreCnt, acks, cyc;
    logic busDone;

    // Reset state
    idleInputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstMemReq",   32'(mem_req),   32'd0);
    checkOutput("rstMemWe",    32'(mem_we),    32'd0);
    checkOutput("rstMemAddr",  mem_addr,       32'd0);
    checkOutput("rstMemSize",  32'(mem_size),  32'd0);
    checkOutput("rstMemWdata", mem_wdata,      32'd0);
    checkOutput("rstDbgAck",   32'(dbg_ack),   32'd0);
    checkOutput("rstDbgRdata", dbg_rdata,      32'd0);
    checkOutput("rstWaitIdle", 32'(core_wait), 32'd0);
    core_rden = 1'b1;
    #1;
    checkOutput("rstWaitPend", 32'(core_wait), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("rstHoldReq",  32'(mem_req),   32'd0);

    // Core-only read, zero-wait memory
    @(negedge clk);
    rst       = 1'b1;
    core_rden = 1'b1;
    core_addr = 32'h100;
    core_size = SIZE_WORD;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("rdWaitIdle", 32'(core_wait), 32'd1);
    checkOutput("rdReqIdle",  32'(mem_req),   32'd0);
    @(negedge clk);
    #1;
    checkOutput("rdReq",   32'(mem_req),   32'd1);
    checkOutput("rdWait",  32'(core_wait), 32'd0);
    checkOutput("rdData",  core_rdata,     32'hDEADBEEF);
    checkOutput("rdAddr",  mem_addr,       32'h100);
    checkOutput("rdWe",    32'(mem_we),    32'd0);
    @(negedge clk);
    core_rden = 1'b0;
    #1;
    checkOutput("rdReqDone", 32'(mem_req), 32'd0);

    // Debug write with three memory wait cycles
    @(negedge clk);
    mem_ready = 1'b0;
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 32'h200;
    dbg_size  = SIZE_WORD;
    dbg_wdata = 32'h12345678;
    #1;
    checkOutput("dwReqIdle", 32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) mem_ready = 1'b1;
      #1;
      checkOutput("dwReq",   32'(mem_req),  32'd1);
      checkOutput("dwWe",    32'(mem_we),   32'd1);
      checkOutput("dwAddr",  mem_addr,      32'h200);
      checkOutput("dwWdata", mem_wdata,     32'h12345678);
      checkOutput("dwSize",  32'(mem_size), 32'(SIZE_WORD));
      checkOutput("dwNoAck", 32'(dbg_ack),  32'd0);
    end
    @(negedge clk);
    #1;
    checkOutput("dwAck",     32'(dbg_ack), 32'd1);
    checkOutput("dwReqDone", 32'(mem_req), 32'd0);
    dbg_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("dwAckOnce", 32'(dbg_ack), 32'd0);

    // Starvation: continuous core traffic, debug held high; expect the debug
    // grant after age reaches the limit and again after it restarts from 0.
    @(negedge clk);
    core_rden = 1'b1;
    core_wren = 1'b0;
    core_addr = 32'h300;
    dbg_req   = 1'b1;
    dbg_we    = 1'b0;
    dbg_addr  = 32'h400;
    mem_rdata = 32'hCAFE0001;
    mem_ready = 1'b1;
    coreCnt   = 0;
    acks      = 0;
    cyc       = 0;
    while (acks < 2 && cyc < 100) begin
      #1;
      if (core_rden && !core_wait) coreCnt++;
      if (dbg_ack) begin
        acks++;
        checkOutput((acks == 1) ? "starveRound1" : "starveRound2", 32'(coreCnt), 32'd4);
        checkOutput("starveRdata", dbg_rdata, 32'hCAFE0001);
        coreCnt = 0;
      end
      if (acks == 2) break;
      cyc++;
      @(negedge clk);
    end
    if (acks < 2) checkOutput("starveTimeout", 32'(acks), 32'd2);
    dbg_req   = 1'b0;
    core_rden = 1'b0;

    // Reset in the middle of a debug transaction
    @(negedge clk);
    mem_ready = 1'b0;
    dbg_req   = 1'b1;
    dbg_we    = 1'b0;
    dbg_addr  = 32'h500;
    @(negedge clk);
    #1;
    checkOutput("rmReqBusy", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rmReqAbort", 32'(mem_req), 32'd0);
    checkOutput("rmNoAck",    32'(dbg_ack), 32'd0);
    rst       = 1'b1;
    dbg_req   = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rmNoAckLate", 32'(dbg_ack), 32'd0);
    checkOutput("rmReqIdle",   32'(mem_req), 32'd0);

    // Read+write conflict, with a debug request withdrawn before its grant
    @(negedge clk);
    core_rden  = 1'b1;
    core_wren  = 1'b1;
    core_addr  = 32'h600;
    core_size  = SIZE_HALF;
    core_wdata = 32'hAAAA5555;
    dbg_req    = 1'b1;
    #1;
    checkOutput("rwWaitIdle", 32'(core_wait), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("rwReq",   32'(mem_req),   32'd1);
    checkOutput("rwWe",    32'(mem_we),    32'd1);
    checkOutput("rwAddr",  mem_addr,       32'h600);
    checkOutput("rwWdata", mem_wdata,      32'hAAAA5555);
    checkOutput("rwWait",  32'(core_wait), 32'd0);
    dbg_req = 1'b0;
    @(negedge clk);
    core_rden = 1'b0;
    core_wren = 1'b0;
    #1;
    checkOutput("rwBubble", 32'(mem_req), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("wdNoReq", 32'(mem_req), 32'd0);
      checkOutput("wdNoAck", 32'(dbg_ack), 32'd0);
    end

    // Random traffic against the scoreboard
    idleInputs();
    coreActive     = 1'b0;
    coreDone       = 1'b0;
    dbgActive      = 1'b0;
    dbgPendingAck  = 1'b0;
    dbgExpIsRead   = 1'b0;
    dbgExpRd       = '0;
    prevReq        = 1'b0;
    prevDone       = 1'b0;
    capWe          = 1'b0;
    capAddr        = '0;
    capWdata       = '0;
    capSize        = SIZE_BYTE;
    coresDuringDbg = 0;
    coreWaitCyc    = 0;
    dbgWaitCyc     = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      applyStimulus();
      #1;
      busDone  = mem_req && mem_ready;
      coreDone = (core_rden || core_wren) && !core_wait;

      if (prevDone) begin
        checkOutput("bubble", 32'(mem_req), 32'd0);
      end else if (mem_req && prevReq) begin
        checkOutput("holdWe",    32'(mem_we),   32'(capWe));
        checkOutput("holdAddr",  mem_addr,      capAddr);
        checkOutput("holdSize",  32'(mem_size), 32'(capSize));
        checkOutput("holdWdata", mem_wdata,     capWdata);
      end
      if (mem_req && !prevReq) begin
        capWe    = mem_we;
        capAddr  = mem_addr;
        capSize  = mem_size;
        capWdata = mem_wdata;
      end

      checkOutput("dbgAck", 32'(dbg_ack), 32'(dbgPendingAck));
      if (dbg_ack && dbgPendingAck && dbgExpIsRead)
        checkOutput("dbgRdata", dbg_rdata, dbgExpRd);
      dbgPendingAck = 1'b0;

      if (coreDone) begin
        checkOutput("coreBus",  32'(busDone),  32'd1);
        checkOutput("coreAddr", mem_addr,      core_addr);
        checkOutput("coreWe",   32'(mem_we),   32'(core_wren));
        checkOutput("coreSize", 32'(mem_size), 32'(core_size));
        if (core_wren) begin
          checkOutput("coreWdata", mem_wdata, core_wdata);
          memModel[core_addr] = core_wdata;
        end else begin
          checkOutput("coreRdata", core_rdata, memRead(core_addr));
        end
        if (dbgActive) coresDuringDbg++;
        coreWaitCyc = 0;
      end else if (busDone) begin
        checkOutput("dbgOwner", 32'(dbgActive), 32'd1);
        checkOutput("dbgAddr",  mem_addr,       dbg_addr);
        checkOutput("dbgWe",    32'(mem_we),    32'(dbg_we));
        checkOutput("dbgSize",  32'(mem_size),  32'(dbg_size));
        if (dbg_we) checkOutput("dbgWdata", mem_wdata, dbg_wdata);
        checkOutput("starveBound", 32'(coresDuringDbg <= STARVE), 32'd1);
        dbgPendingAck  = 1'b1;
        dbgExpIsRead   = !dbg_we;
        dbgExpRd       = memRead(dbg_addr);
        if (dbg_we) memModel[dbg_addr] = dbg_wdata;
        coresDuringDbg = 0;
        dbgWaitCyc     = 0;
      end

      if (coreActive && core_wait) coreWaitCyc++;
      if (dbgActive && !busDone) dbgWaitCyc++;
      if (coreWaitCyc > 200) begin
        checkOutput("coreTimeout", 32'(coreWaitCyc), 32'd200);
        coreWaitCyc = 0;
      end
      if (dbgWaitCyc > 200) begin
        checkOutput("dbgTimeout", 32'(dbgWaitCyc), 32'd200);
        dbgWaitCyc = 0;
      end

      prevReq  = mem_req;
      prevDone = busDone;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
